// File: rtl/iq_free_list.sv
// Circular free list of issue-queue entry indices.
// Pops dispatch write addresses, pushes back issued entries.
module iq_free_list #(
  parameter int DEPTH          = 32,
  parameter int INDEX          = 5,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_i,
  input  logic [DISPATCH_WIDTH-1:0]       alloc_vld_i,
  output logic [DISPATCH_WIDTH*INDEX-1:0] alloc_idx_o,
  output logic                            alloc_rdy_o,
  input  logic [ISSUE_WIDTH-1:0]          free_vld_i,
  input  logic [ISSUE_WIDTH*INDEX-1:0]    free_idx_i,
  output logic [INDEX:0]                  free_cnt_o,
  output logic                            err_o
);

  localparam int CW = INDEX + 1;

  logic [INDEX-1:0] list_q [DEPTH];
  logic [INDEX-1:0] head_q, head_d;
  logic [INDEX-1:0] tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [CW-1:0]    pop_n, push_n;
  logic [CW-1:0]    cnt_pop, cnt_push;
  logic             pop_ok, push_ok;
  logic [INDEX-1:0] wr_addr [ISSUE_WIDTH];
  logic             vld_gap;

  // Lane k reads the k-th entry past head; registered state only.
  always_comb begin
    alloc_idx_o = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      alloc_idx_o[k*INDEX +: INDEX] =
        list_q[head_q + INDEX'(k)];
    end
  end

  assign alloc_rdy_o = cnt_q >= CW'(DISPATCH_WIDTH);
  assign free_cnt_o  = cnt_q;
  assign err_o       = err_q;

  // Pop/push legality, compacted write slots and next pointers.
  always_comb begin
    pop_n  = '0;
    push_n = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      pop_n = pop_n + CW'(alloc_vld_i[k]);
    end
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      wr_addr[k] = tail_q + push_n[INDEX-1:0];
      push_n     = push_n + CW'(free_vld_i[k]);
    end
    pop_ok   = pop_n <= cnt_q;
    cnt_pop  = pop_ok ? cnt_q - pop_n : cnt_q;
    cnt_push = cnt_pop + push_n;
    push_ok  = cnt_push <= CW'(DEPTH);
    head_d   = pop_ok ? head_q + pop_n[INDEX-1:0]
                      : head_q;
    tail_d   = push_ok ? tail_q + push_n[INDEX-1:0]
                       : tail_q;
    cnt_d    = push_ok ? cnt_push : cnt_pop;
    err_d    = err_q | ~pop_ok | ~push_ok;
  end

  // List storage, pointers, count and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        list_q[i] <= INDEX'(i);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CW'(DEPTH);
      err_q  <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        list_q[i] <= INDEX'(i);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CW'(DEPTH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (push_ok && free_vld_i[k]) begin
          list_q[wr_addr[k]] <=
            free_idx_i[k*INDEX +: INDEX];
        end
      end
    end
  end

  assign vld_gap =
    |(alloc_vld_i[DISPATCH_WIDTH-1:1] &
      ~alloc_vld_i[DISPATCH_WIDTH-2:0]);

  a_alloc_packed: assert property (
    @(posedge clk) disable iff (reset) !vld_gap);

endmodule

// File: tb/tb_iq_free_list.sv
// Bench for iq_free_list.
// Queue-based reference model, directed and random tests.
module tb_iq_free_list;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic [3:0]  alloc_vld_i;
  logic [19:0] alloc_idx_o;
  logic        alloc_rdy_o;
  logic [3:0]  free_vld_i;
  logic [19:0] free_idx_i;
  logic [5:0]  free_cnt_o;
  logic        err_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [4:0] mq[$];
  bit         merr;

  iq_free_list dut (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_i),
    .alloc_vld_i(alloc_vld_i),
    .alloc_idx_o(alloc_idx_o),
    .alloc_rdy_o(alloc_rdy_o),
    .free_vld_i (free_vld_i),
    .free_idx_i (free_idx_i),
    .free_cnt_o (free_cnt_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mq.push_back(5'(i));
  endtask

  task automatic step(input bit fl, input logic [3:0] av,
                      input logic [3:0] fv,
                      input logic [19:0] fi);
    int p, qn, c;
    bit push;
    flush_i     = fl;
    alloc_vld_i = av;
    free_vld_i  = fv;
    free_idx_i  = fi;
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      p  = $countones(av);
      qn = $countones(fv);
      c  = mq.size();
      if (p > c) begin
        merr = 1'b1;
        p = 0;
      end
      push = (c - p + qn) <= 32;
      if (!push) merr = 1'b1;
      repeat (p) void'(mq.pop_front());
      if (push)
        for (int k = 0; k < 4; k++)
          if (fv[k]) mq.push_back(fi[k*5 +: 5]);
    end
    #1;
    flush_i     = 1'b0;
    alloc_vld_i = '0;
    free_vld_i  = '0;
    free_idx_i  = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    merr = 1'b0;
  endtask

  task automatic test_reset();
    tot_cnt++;
    if (alloc_idx_o !== {5'd3, 5'd2, 5'd1, 5'd0})
      $display("FAIL rst_idx got %h want %h",
               alloc_idx_o, {5'd3, 5'd2, 5'd1, 5'd0});
    else pass_cnt++;
    tot_cnt++;
    if (free_cnt_o !== 6'd32)
      $display("FAIL rst_cnt got %0d want 32", free_cnt_o);
    else pass_cnt++;
    tot_cnt++;
    if (alloc_rdy_o !== 1'b1)
      $display("FAIL rst_rdy got %b want 1", alloc_rdy_o);
    else pass_cnt++;
    tot_cnt++;
    if (err_o !== 1'b0)
      $display("FAIL rst_err got %b want 0", err_o);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        tot_cnt++;
        if (alloc_idx_o[k*5 +: 5] !== 5'(4*c + k))
          $display("FAIL drain_idx c%0d l%0d got %0d want %0d",
                   c, k, alloc_idx_o[k*5 +: 5], 4*c + k);
        else pass_cnt++;
      end
      step(0, 4'hF, 4'h0, '0);
    end
    tot_cnt++;
    if (free_cnt_o !== 6'd0 || alloc_rdy_o !== 1'b0 ||
        err_o !== 1'b0)
      $display("FAIL empty got cnt=%0d rdy=%b err=%b want 0/0/0",
               free_cnt_o, alloc_rdy_o, err_o);
    else pass_cnt++;
    step(0, 4'hF, 4'h0, '0);
    tot_cnt++;
    if (err_o !== 1'b1 || free_cnt_o !== 6'd0)
      $display("FAIL underflow got err=%b cnt=%0d want 1/0",
               err_o, free_cnt_o);
    else pass_cnt++;
    tot_cnt++;
    if (alloc_idx_o !== {5'd3, 5'd2, 5'd1, 5'd0})
      $display("FAIL underflow_head got %h want %h",
               alloc_idx_o, {5'd3, 5'd2, 5'd1, 5'd0});
    else pass_cnt++;
  endtask

  task automatic test_free_wrap();
    step(0, 4'h0, 4'b1010, {5'd3, 5'd0, 5'd7, 5'd0});
    tot_cnt++;
    if (free_cnt_o !== 6'd2 ||
        alloc_idx_o[9:0] !== {5'd3, 5'd7})
      $display("FAIL free_wrap got cnt=%0d l0=%0d l1=%0d want 2/7/3",
               free_cnt_o, alloc_idx_o[4:0], alloc_idx_o[9:5]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    step(0, 4'h0, 4'b0011, {5'd0, 5'd0, 5'd10, 5'd9});
    tot_cnt++;
    if (free_cnt_o !== 6'd4 ||
        alloc_idx_o !== {5'd10, 5'd9, 5'd3, 5'd7})
      $display("FAIL b2b_pre got cnt=%0d idx=%h want 4/%h",
               free_cnt_o, alloc_idx_o,
               {5'd10, 5'd9, 5'd3, 5'd7});
    else pass_cnt++;
    step(0, 4'hF, 4'hF, {5'd23, 5'd22, 5'd21, 5'd20});
    tot_cnt++;
    if (free_cnt_o !== 6'd4 ||
        alloc_idx_o !== {5'd23, 5'd22, 5'd21, 5'd20})
      $display("FAIL b2b got cnt=%0d idx=%h want 4/%h",
               free_cnt_o, alloc_idx_o,
               {5'd23, 5'd22, 5'd21, 5'd20});
    else pass_cnt++;
    tot_cnt++;
    if (err_o !== 1'b1)
      $display("FAIL err_sticky got %b want 1", err_o);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    pulse_reset();
    @(posedge clk);
    #1;
    step(0, 4'h0, 4'b0001, {15'd0, 5'd5});
    tot_cnt++;
    if (free_cnt_o !== 6'd32 || err_o !== 1'b1 ||
        alloc_idx_o !== {5'd3, 5'd2, 5'd1, 5'd0})
      $display("FAIL overflow got cnt=%0d err=%b idx=%h want 32/1/%h",
               free_cnt_o, err_o, alloc_idx_o,
               {5'd3, 5'd2, 5'd1, 5'd0});
    else pass_cnt++;
    step(0, 4'hF, 4'hF, {5'd30, 5'd29, 5'd28, 5'd27});
    tot_cnt++;
    if (free_cnt_o !== 6'd32 ||
        alloc_idx_o !== {5'd7, 5'd6, 5'd5, 5'd4})
      $display("FAIL full_swap got cnt=%0d idx=%h want 32/%h",
               free_cnt_o, alloc_idx_o,
               {5'd7, 5'd6, 5'd5, 5'd4});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    step(0, 4'h7, 4'h0, '0);
    step(0, 4'h3, 4'h1, {15'd0, 5'd17});
    step(1, 4'hF, 4'hF, 20'($urandom));
    tot_cnt++;
    if (free_cnt_o !== 6'd32 || alloc_rdy_o !== 1'b1 ||
        alloc_idx_o !== {5'd3, 5'd2, 5'd1, 5'd0})
      $display("FAIL flush got cnt=%0d rdy=%b idx=%h want 32/1/%h",
               free_cnt_o, alloc_rdy_o, alloc_idx_o,
               {5'd3, 5'd2, 5'd1, 5'd0});
    else pass_cnt++;
    tot_cnt++;
    if (err_o !== 1'b1)
      $display("FAIL flush_err got %b want 1", err_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    step(0, 4'hF, 4'h0, '0);
    step(0, 4'hF, 4'h0, '0);
    #2;
    reset = 1'b1;
    #1;
    tot_cnt++;
    if (free_cnt_o !== 6'd32 || err_o !== 1'b0 ||
        alloc_idx_o !== {5'd3, 5'd2, 5'd1, 5'd0})
      $display("FAIL async_rst got cnt=%0d err=%b idx=%h want 32/0/%h",
               free_cnt_o, err_o, alloc_idx_o,
               {5'd3, 5'd2, 5'd1, 5'd0});
    else pass_cnt++;
    reset = 1'b0;
    model_reset();
    merr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int p, n;
    logic [3:0] av;
    for (int it = 0; it < 400; it++) begin
      p  = $urandom_range(0, 4);
      av = 4'((1 << p) - 1);
      step(($urandom_range(0, 49) == 0), av,
           4'($urandom), 20'($urandom));
      n = mq.size();
      tot_cnt++;
      if (free_cnt_o !== 6'(n))
        $display("FAIL rnd_cnt it%0d got %0d want %0d",
                 it, free_cnt_o, n);
      else pass_cnt++;
      tot_cnt++;
      if (alloc_rdy_o !== (n >= 4) || err_o !== merr)
        $display("FAIL rnd_flags it%0d got rdy=%b err=%b want %b/%b",
                 it, alloc_rdy_o, err_o, (n >= 4), merr);
      else pass_cnt++;
      for (int k = 0; k < 4 && k < n; k++) begin
        tot_cnt++;
        if (alloc_idx_o[k*5 +: 5] !== mq[k])
          $display("FAIL rnd_idx it%0d l%0d got %0d want %0d",
                   it, k, alloc_idx_o[k*5 +: 5], mq[k]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    flush_i     = 1'b0;
    alloc_vld_i = '0;
    free_vld_i  = '0;
    free_idx_i  = '0;
    model_reset();
    merr = 1'b0;
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_drain();
    test_free_wrap();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
